bcd_time_counter: RTL and testbench

BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

---
 rtl/crono_pkg.sv | 21 ++
 rtl/bcd_digit.sv | 41 ++++
 rtl/bcd_time_counter.sv | 114 +++++++++++
 tb/tb_bcd_time_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/crono_pkg.sv
// Shared definitions for the BCD time-counter family.
// Contents:
//   bcd_t      - 4-bit BCD digit
//   BCD_MAX    - largest legal BCD digit (9)
//   MOD_SEC, MOD_MIN, MOD_HOUR - common count moduli
//   bcd_value  - numeric value of a two-digit BCD pair (digits may be illegal)
package crono_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam int   MOD_SEC  = 60;
  localparam int   MOD_MIN  = 60;
  localparam int   MOD_HOUR = 24;

  // 8 bits so that an illegal pair such as FF (165) does not overflow.
  function automatic logic [7:0] bcd_value(input bcd_t hi, input bcd_t lo);
    return 8'(hi) * 8'd10 + 8'(lo);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: registered digit with increment/decrement and wrap.
// Ports:
//   clk, reset    - clock, synchronous active-low reset
//   load/load_val - synchronous preset (takes priority over step)
//   step          - advance one position this cycle
//   up            - 1 = increment, 0 = decrement
//   limit         - highest value of this digit for the current count;
//                   counting up past it wraps to 0, counting down from 0
//                   wraps to it
//   digit         - current digit value
//   wrap_out      - combinational: this cycle's step wraps the digit
module bcd_digit
  import crono_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  bcd_t load_val,
  input  logic step,
  input  logic up,
  input  bcd_t limit,
  output bcd_t digit,
  output logic wrap_out
);

  assign wrap_out = step && (up ? (digit == limit) : (digit == 4'd0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (step) begin
      if (wrap_out)
        digit <= up ? 4'd0 : limit;
      else
        digit <= up ? digit + 4'd1 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// Two-digit BCD up/down counter with programmable modulus, validated
// preset, wrap pulse and optional lap capture.
// Parameter: MODULUS (2..100), count runs 0 .. MODULUS-1.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   tick_en, count_up     - step qualifier and direction
//   load, load_low/high   - preset strobe and BCD preset digits
//   cnt_low/high          - current BCD value
//   carry                 - one-cycle pulse when the wrapped value appears
//   load_err              - one-cycle pulse when a preset is rejected
//   lap_req, lap_low/high - lap capture strobe and captured value
// Build option: define CRONO_LAP_EN to implement the lap registers;
// otherwise lap outputs are tied to 0 and lap_req is ignored.
module bcd_time_counter
  import crono_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_en,
  input  logic count_up,
  input  logic load,
  input  bcd_t load_low,
  input  bcd_t load_high,
  output bcd_t cnt_low,
  output bcd_t cnt_high,
  output logic carry,
  output logic load_err,
  input  logic lap_req,
  output bcd_t lap_low,
  output bcd_t lap_high
);

  // Terminal value MODULUS-1 split into tens/units digits.
  localparam int   TERM    = MODULUS - 1;
  localparam bcd_t TERM_HI = bcd_t'(TERM / 10);
  localparam bcd_t TERM_LO = bcd_t'(TERM % 10);

  logic legal;
  logic load_ok;
  logic step_units;
  logic units_wrap;
  logic tens_wrap;
  bcd_t units_limit;

  assign legal = (load_low <= BCD_MAX) && (load_high <= BCD_MAX) &&
                 (bcd_value(load_high, load_low) < 8'(MODULUS));
  assign load_ok    = load && legal;
  // Any load attempt, accepted or not, suppresses the tick.
  assign step_units = tick_en && !load;

  // The units ceiling is TERM_LO only when the tens digit is (or is about
  // to become) TERM_HI: counting up at tens==TERM_HI, or counting down
  // from tens==0 where the tens digit wraps to TERM_HI.
  always_comb begin
    units_limit = BCD_MAX;
    if (count_up ? (cnt_high == TERM_HI) : (cnt_high == 4'd0))
      units_limit = TERM_LO;
  end

  bcd_digit u_units (
    .clk      (clk),
    .reset    (reset),
    .load     (load_ok),
    .load_val (load_low),
    .step     (step_units),
    .up       (count_up),
    .limit    (units_limit),
    .digit    (cnt_low),
    .wrap_out (units_wrap)
  );

  bcd_digit u_tens (
    .clk      (clk),
    .reset    (reset),
    .load     (load_ok),
    .load_val (load_high),
    .step     (units_wrap),
    .up       (count_up),
    .limit    (TERM_HI),
    .digit    (cnt_high),
    .wrap_out (tens_wrap)
  );

  // Status pulses registered alongside the digits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= units_wrap && tens_wrap;
      load_err <= load && !legal;
    end
  end

`ifdef CRONO_LAP_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      lap_low  <= '0;
      lap_high <= '0;
    end else if (lap_req) begin
      lap_low  <= cnt_low;
      lap_high <= cnt_high;
    end
  end
`else
  logic lap_req_unused;
  assign lap_req_unused = lap_req;
  assign lap_low        = '0;
  assign lap_high       = '0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
module tb_bcd_time_counter;
  import crono_pkg::*;

`ifdef CRONO_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick_en = 1'b0, count_up = 1'b1, load = 1'b0, lap_req = 1'b0;
  bcd_t load_low = '0, load_high = '0;

  bcd_t lo0, hi0, llo0, lhi0, lo1, hi1, llo1, lhi1;
  logic c0, e0, c1, e1;

  always #5 clk = ~clk;

  bcd_time_counter #(.MODULUS(MOD_SEC)) dut0 (
    .clk(clk), .reset(reset), .tick_en(tick_en), .count_up(count_up),
    .load(load), .load_low(load_low), .load_high(load_high),
    .cnt_low(lo0), .cnt_high(hi0), .carry(c0), .load_err(e0),
    .lap_req(lap_req), .lap_low(llo0), .lap_high(lhi0));

  bcd_time_counter #(.MODULUS(MOD_HOUR)) dut1 (
    .clk(clk), .reset(reset), .tick_en(tick_en), .count_up(count_up),
    .load(load), .load_low(load_low), .load_high(load_high),
    .cnt_low(lo1), .cnt_high(hi1), .carry(c1), .load_err(e1),
    .lap_req(lap_req), .lap_low(llo1), .lap_high(lhi1));

  typedef struct {
    int    sel;
    int    val;
    bit    c;
    bit    e;
    int    lap;
    string name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int elap   = 0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // Monitor: one expected entry per clocked stimulus cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      if (x.sel == 0) begin
        chk({x.name, " value"}, 10 * int'(hi0) + int'(lo0), x.val);
        chk({x.name, " carry"}, int'(c0), int'(x.c));
        chk({x.name, " load_err"}, int'(e0), int'(x.e));
        chk({x.name, " lap"}, 10 * int'(lhi0) + int'(llo0), x.lap);
      end else begin
        chk({x.name, " value"}, 10 * int'(hi1) + int'(lo1), x.val);
        chk({x.name, " carry"}, int'(c1), int'(x.c));
        chk({x.name, " load_err"}, int'(e1), int'(x.e));
        chk({x.name, " lap"}, 10 * int'(lhi1) + int'(llo1), x.lap);
      end
    end
  end

  // Drive one cycle of inputs and queue the values expected after the edge.
  task automatic cyc(input bit r, input bit t, input bit u, input bit l,
                     input bcd_t lh, input bcd_t ll, input bit lp,
                     input int s, input int ev, input bit ec, input bit ee,
                     input string nm);
    exp_t x;
    @(negedge clk);
    reset = r; tick_en = t; count_up = u; load = l;
    load_high = lh; load_low = ll; lap_req = lp;
    @(posedge clk);
    x.sel = s; x.val = ev; x.c = ec; x.e = ee; x.lap = elap; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic ld(input int s, input int v, input string nm);
    cyc(1, 0, 1, 1, bcd_t'(v / 10), bcd_t'(v % 10), 0, s, v, 0, 0, nm);
  endtask

  task automatic tk(input int s, input bit u, input int ev, input bit ec,
                    input string nm);
    cyc(1, 1, u, 0, 4'd0, 4'd0, 0, s, ev, ec, 0, nm);
  endtask

  initial begin
    // Reset with every other control active
    cyc(0, 1, 1, 1, 4'd1, 4'd2, 1, 0, 0, 0, 0, "reset0");
    cyc(0, 1, 1, 1, 4'd1, 4'd2, 1, 1, 0, 0, 0, "reset1");

    // Full count-up over MODULUS=60: carry only as 00 reappears
    for (int i = 1; i <= 60; i++)
      tk(0, 1, i % 60, (i == 60), "up60");

    // MODULUS=24 underflow and overflow
    ld(1, 0, "m24 load00");
    tk(1, 0, 23, 1, "m24 dn 00->23");
    tk(1, 0, 22, 0, "m24 dn 23->22");
    cyc(1, 0, 0, 0, 4'd0, 4'd0, 0, 1, 22, 0, 0, "m24 hold");
    ld(1, 23, "m24 load23");
    tk(1, 1, 0, 1, "m24 up 23->00");
    // dut0 now holds 24

    // Rejected presets keep value and ignore tick
    cyc(1, 1, 1, 1, 4'd7, 4'hA, 0, 0, 24, 0, 1, "load 7A");
    cyc(1, 1, 1, 1, 4'd6, 4'd5, 0, 0, 24, 0, 1, "load 65");
    cyc(1, 0, 1, 1, 4'd4, 4'd5, 0, 0, 45, 0, 0, "load 45");
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 45, 0, 0, "idle 45");

    // Wrap at 59 vs. load overriding tick at 59
    ld(0, 59, "load59");
    tk(0, 1, 0, 1, "up 59->00");
    tk(0, 1, 1, 0, "up 00->01");
    ld(0, 59, "load59b");
    cyc(1, 1, 1, 1, 4'd3, 4'd0, 0, 0, 30, 0, 0, "load30+tick");

    // Borrow across the decade
    ld(0, 10, "load10");
    tk(0, 0, 9, 0, "dn 10->09");
    ld(0, 20, "load20");
    tk(0, 0, 19, 0, "dn 20->19");

    // Lap capture with simultaneous tick
    ld(0, 19, "load19");
    elap = LAP ? 19 : 0;
    cyc(1, 1, 1, 0, 4'd0, 4'd0, 1, 0, 20, 0, 0, "lap+tick");
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 20, 0, 0, "lap hold");

    // Reset mid-count overrides tick, load and lap
    ld(0, 37, "load37");
    elap = LAP ? 37 : 0;
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 1, 0, 37, 0, 0, "lap37");
    elap = 0;
    cyc(0, 1, 1, 1, 4'd1, 4'd2, 1, 0, 0, 0, 0, "reset mid");
    tk(0, 1, 1, 0, "after reset");

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
